// File: rtl/msg_pkg.sv
// Shared definitions for the message pipeline (loader, encrypt, decrypt).
// Contents:
//   byte_t            8-bit plaintext/ciphertext byte
//   loader_state_e    two-state frame loader FSM encoding
//   UPPER_A/Z,
//   LOWER_A/Z         ASCII letter range bounds
//   PAD_CHAR_DEFAULT  fill byte for frames cut short by the end of a message
//   is_special()      1 when a byte is not an ASCII letter
package msg_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } loader_state_e;

    localparam byte_t UPPER_A          = 8'h41;
    localparam byte_t UPPER_Z          = 8'h5A;
    localparam byte_t LOWER_A          = 8'h61;
    localparam byte_t LOWER_Z          = 8'h7A;
    localparam byte_t PAD_CHAR_DEFAULT = 8'h20;

    // Unsigned compare, so 8'h80-8'hFF land outside both ranges and count as special.
    function automatic logic is_special(input byte_t b);
        logic upper_s;
        logic lower_s;
        upper_s = (b >= UPPER_A) && (b <= UPPER_Z);
        lower_s = (b >= LOWER_A) && (b <= LOWER_Z);
        return !(upper_s || lower_s);
    endfunction

endpackage

// File: rtl/char_classifier.sv
// Combinational byte classifier for the frame loader.
// Ports:
//   char_in  in  8  byte to classify
//   special  out 1  1 when char_in is not in 'A'..'Z' or 'a'..'z'
module char_classifier
    import msg_pkg::*;
(
    input  byte_t char_in,
    output logic  special
);

    assign special = is_special(char_in);

endmodule

// File: rtl/msg_frame_loader.sv
// Plaintext frame loader feeding the encrypt stage.
// Collects one byte per cycle into a MSG_LEN-byte frame, tags every non-letter
// byte in special_mask, pads short frames (ended by in_last) with PAD_CHAR and
// offers the frame downstream with a valid/ready handshake.
// Ports:
//   clk           in   1              rising-edge clock
//   rst_n         in   1              synchronous active-low reset
//   in_valid      in   1              in_data valid
//   in_ready      out  1              byte accepted this cycle when in_valid is high
//   in_data       in   8              plaintext byte
//   in_last       in   1              final byte of the message
//   frame_valid   out  1              frame outputs valid and stable
//   frame_ready   in   1              consumer takes the frame
//   frame_data    out  8 x MSG_LEN    index 0 = first byte received
//   special_mask  out  MSG_LEN        bit i set: frame_data[i] is not a letter
//   frame_len     out  CW             number of real (non-pad) bytes
module msg_frame_loader
    import msg_pkg::*;
#(
    parameter int    MSG_LEN  = 12,
    parameter byte_t PAD_CHAR = PAD_CHAR_DEFAULT,
    localparam int   CW       = $clog2(MSG_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [7:0]         frame_data [0:MSG_LEN-1],
    output logic [MSG_LEN-1:0] special_mask,
    output logic [CW-1:0]      frame_len
);

    loader_state_e state_r;
    logic [CW-1:0] cnt_r;
    logic          special_s;
    logic          accept_s;
    logic          complete_s;

    char_classifier u_classifier (
        .char_in (in_data),
        .special (special_s)
    );

    // The loader only takes bytes while filling; HOLD blocks the input side.
    assign in_ready = (state_r == ST_FILL);

    // Byte acceptance and frame-completion decode for the current cycle.
    always_comb begin
        accept_s   = 1'b0;
        complete_s = 1'b0;
        if (in_valid && in_ready) begin
            accept_s   = 1'b1;
            complete_s = in_last || (cnt_r == CW'(MSG_LEN - 1));
        end else begin
            accept_s   = 1'b0;
            complete_s = 1'b0;
        end
    end

    // Loader FSM with frame, mask, length and valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_FILL;
            cnt_r        <= '0;
            frame_valid  <= 1'b0;
            frame_len    <= '0;
            special_mask <= '1;
            for (int i = 0; i < MSG_LEN; i++) begin
                frame_data[i] <= PAD_CHAR;
            end
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (accept_s) begin
                        // Write the new byte at cnt; on completion pad every slot
                        // above it so stale bytes from an earlier frame never leak.
                        for (int i = 0; i < MSG_LEN; i++) begin
                            if (CW'(i) == cnt_r) begin
                                frame_data[i]   <= in_data;
                                special_mask[i] <= special_s;
                            end else if (complete_s && (CW'(i) > cnt_r)) begin
                                frame_data[i]   <= PAD_CHAR;
                                special_mask[i] <= 1'b1;
                            end
                        end
                        cnt_r <= cnt_r + CW'(1);
                        if (complete_s) begin
                            state_r     <= ST_HOLD;
                            frame_valid <= 1'b1;
                            frame_len   <= cnt_r + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_ready) begin
                        state_r     <= ST_FILL;
                        cnt_r       <= '0;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_FILL;
                    cnt_r       <= '0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_frame_loader.sv
// Directed bench for msg_frame_loader: reset, full/short/split frames,
// back-pressure, classifier range edges and reset in the middle of a frame.
module tb_msg_frame_loader;

    localparam int MSG_LEN = 12;
    localparam int CW      = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic               in_last;
    logic               frame_valid;
    logic               frame_ready;
    logic [7:0]         frame_data [0:MSG_LEN-1];
    logic [MSG_LEN-1:0] special_mask;
    logic [CW-1:0]      frame_len;

    int total = 0;
    int bad   = 0;

    logic [95:0] held_frame;
    logic [95:0] pads12;

    always #5 clk = ~clk;

    msg_frame_loader #(
        .MSG_LEN  (MSG_LEN),
        .PAD_CHAR (8'h20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .special_mask (special_mask),
        .frame_len    (frame_len)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // frame_data flattened with index 0 in the top byte, matching string literal order.
    function automatic logic [95:0] packed_frame();
        logic [95:0] r;
        r = 96'h0;
        for (int i = 0; i < MSG_LEN; i++) begin
            r[95-8*i -: 8] = frame_data[i];
        end
        return r;
    endfunction

    // Drive n bytes from the top of s, one per cycle; called and returns at a negedge.
    task automatic send(input logic [95:0] s, input int n, input logic last_flag);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = s[95-8*k -: 8];
            in_last  = last_flag && (k == n - 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        pads12      = {12{8'h20}};
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        frame_ready = 1'b0;

        // 1: reset held for two edges
        repeat (2) @(negedge clk);
        chk("rst_valid", 96'(frame_valid), 96'd0);
        chk("rst_ready", 96'(in_ready), 96'd1);
        chk("rst_mask", 96'(special_mask), 96'hFFF);
        chk("rst_len", 96'(frame_len), 96'd0);
        chk("rst_data", packed_frame(), pads12);
        rst_n = 1'b1;
        step();

        // 2: full frame of specials, consumer always ready
        frame_ready = 1'b1;
        send("~ !@#$%^&*()", 11, 1'b0);
        chk("full_not_yet", 96'(frame_valid), 96'd0);
        send({8'h29, 88'h0}, 1, 1'b0);
        chk("full_valid", 96'(frame_valid), 96'd1);
        chk("full_ready_low", 96'(in_ready), 96'd0);
        chk("full_data", packed_frame(), "~ !@#$%^&*()");
        chk("full_mask", 96'(special_mask), 96'hFFF);
        chk("full_len", 96'(frame_len), 96'd12);
        step();
        chk("full_taken", 96'(frame_valid), 96'd0);
        chk("full_ready_back", 96'(in_ready), 96'd1);

        // 3: short frame closed by in_last
        send({"Hi!", 72'h0}, 3, 1'b1);
        chk("short_valid", 96'(frame_valid), 96'd1);
        chk("short_data", packed_frame(), {"Hi!", {9{8'h20}}});
        chk("short_mask", 96'(special_mask), 96'hFFC);
        chk("short_len", 96'(frame_len), 96'd3);
        step();
        chk("short_taken", 96'(frame_valid), 96'd0);

        // 4: back-pressure for five cycles with bytes offered on the input
        frame_ready = 1'b0;
        send("Hello, World", 12, 1'b0);
        chk("bp_data", packed_frame(), "Hello, World");
        chk("bp_mask", 96'(special_mask), 96'h060);
        chk("bp_len", 96'(frame_len), 96'd12);
        held_frame = packed_frame();
        in_valid   = 1'b1;
        in_data    = 8'h58;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_valid", 96'(frame_valid), 96'd1);
            chk("bp_hold_ready", 96'(in_ready), 96'd0);
            chk("bp_hold_data", packed_frame(), held_frame);
        end
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        step();
        chk("bp_release_valid", 96'(frame_valid), 96'd0);
        chk("bp_release_ready", 96'(in_ready), 96'd1);

        // classifier range edges just inside/outside both letter ranges plus a high byte
        send({8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'hC1, 24'h0}, 9, 1'b1);
        chk("edge_data", packed_frame(),
            {8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'hC1, {3{8'h20}}});
        chk("edge_mask", 96'(special_mask), 96'hF99);
        chk("edge_len", 96'(frame_len), 96'd9);
        step();

        // 5: 15-letter message split across two frames
        frame_ready = 1'b0;
        send("ABCDEFGHIJKL", 12, 1'b0);
        chk("split1_valid", 96'(frame_valid), 96'd1);
        chk("split1_data", packed_frame(), "ABCDEFGHIJKL");
        chk("split1_mask", 96'(special_mask), 96'h000);
        chk("split1_len", 96'(frame_len), 96'd12);
        frame_ready = 1'b1;
        step();
        send({"MNO", 72'h0}, 3, 1'b1);
        chk("split2_valid", 96'(frame_valid), 96'd1);
        chk("split2_data", packed_frame(), {"MNO", {9{8'h20}}});
        chk("split2_mask", 96'(special_mask), 96'hFF8);
        chk("split2_len", 96'(frame_len), 96'd3);
        step();

        // 6: reset while a frame is partly filled
        send({"abcde", 56'h0}, 5, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 96'(frame_valid), 96'd0);
        chk("midrst_len", 96'(frame_len), 96'd0);
        chk("midrst_mask", 96'(special_mask), 96'hFFF);
        chk("midrst_data", packed_frame(), pads12);
        rst_n = 1'b1;
        chk("midrst_ready", 96'(in_ready), 96'd1);
        send({"Z", 88'h0}, 1, 1'b1);
        chk("midrst_fvalid", 96'(frame_valid), 96'd1);
        chk("midrst_fdata", packed_frame(), {"Z", {11{8'h20}}});
        chk("midrst_fmask", 96'(special_mask), 96'hFFE);
        chk("midrst_flen", 96'(frame_len), 96'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
